// File: rtl/spi_bootloader_host.sv
// Host-side command initiator for the SPI bootloader byte protocol: serialises
// boot / transfer / version requests onto the link and routes payload and response bytes.
module spi_bootloader_host #(
    parameter logic [7:0]  EXPECTED_VERSION = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES   = 1200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_tx_len,
    input  logic [15:0] cmd_rx_len,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        link_out_valid,
    output logic [7:0]  link_out_data,
    input  logic        link_out_ready,
    input  logic        link_in_valid,
    input  logic [7:0]  link_in_data,
    output logic        link_in_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        link_abort,
    output logic [7:0]  version,
    output logic        version_ok
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, H_OP, H_TXL, H_TXH, H_RXL, H_RXH, TX, RX, VER, FIN
    } state_e;

    state_e        state_q;
    logic [1:0]    op_q;
    logic [15:0]   txLen_q;
    logic [15:0]   rxLen_q;
    logic [15:0]   cnt_q;
    logic [TW-1:0] tmo_q;
    logic          done_q;
    logic          error_q;
    logic          abort_q;
    logic [7:0]    version_q;
    logic          versionOk_q;
    logic          outHs;
    logic          inHs;

    // Byte routing: header bytes come from latched fields, payload and
    // responses pass straight through; stray inbound bytes are swallowed.
    always_comb begin
        link_out_valid = 1'b0;
        link_out_data  = 8'h00;
        wr_ready       = 1'b0;
        rd_valid       = 1'b0;
        rd_data        = 8'h00;
        link_in_ready  = 1'b1;
        case (state_q)
            H_OP:  begin link_out_valid = 1'b1; link_out_data = {6'd0, op_q}; end
            H_TXL: begin link_out_valid = 1'b1; link_out_data = txLen_q[7:0]; end
            H_TXH: begin link_out_valid = 1'b1; link_out_data = txLen_q[15:8]; end
            H_RXL: begin link_out_valid = 1'b1; link_out_data = rxLen_q[7:0]; end
            H_RXH: begin link_out_valid = 1'b1; link_out_data = rxLen_q[15:8]; end
            TX: begin
                link_out_valid = wr_valid;
                link_out_data  = wr_data;
                wr_ready       = link_out_ready;
            end
            RX: begin
                rd_valid      = link_in_valid;
                rd_data       = link_in_data;
                link_in_ready = rd_ready;
            end
            default: ;
        endcase
        if (reset) begin
            link_out_valid = 1'b0;
            rd_valid       = 1'b0;
            wr_ready       = 1'b0;
        end
    end

    assign outHs      = link_out_valid && link_out_ready;
    assign inHs       = link_in_valid && link_in_ready;
    assign cmd_ready  = reset || (state_q == IDLE);
    assign busy       = !reset && (state_q != IDLE);
    assign done       = done_q;
    assign error      = error_q;
    assign link_abort = abort_q;
    assign version    = version_q;
    assign version_ok = versionOk_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'd0;
            txLen_q     <= 16'd0;
            rxLen_q     <= 16'd0;
            cnt_q       <= 16'd0;
            tmo_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            abort_q     <= 1'b0;
            version_q   <= 8'h00;
            versionOk_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_q    <= cmd_op;
                    txLen_q <= cmd_tx_len;
                    rxLen_q <= cmd_rx_len;
                    cnt_q   <= 16'd0;
                    state_q <= (cmd_op == 2'd3) ? FIN : H_OP;
                end
                H_OP: if (outHs) begin
                    tmo_q <= '0;
                    case (op_q)
                        2'd0:    state_q <= FIN;
                        2'd2:    state_q <= VER;
                        default: state_q <= H_TXL;
                    endcase
                end
                H_TXL: if (outHs) state_q <= H_TXH;
                H_TXH: if (outHs) state_q <= H_RXL;
                H_RXL: if (outHs) state_q <= H_RXH;
                H_RXH: if (outHs) begin
                    tmo_q <= '0;
                    if (txLen_q != 16'd0)      state_q <= TX;
                    else if (rxLen_q != 16'd0) state_q <= RX;
                    else                       state_q <= FIN;
                end
                TX: if (outHs) begin
                    if (cnt_q == txLen_q - 16'd1) begin
                        cnt_q   <= 16'd0;
                        tmo_q   <= '0;
                        state_q <= (rxLen_q != 16'd0) ? RX : FIN;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                // A byte waiting on a stalled sink freezes the timeout.
                RX: begin
                    if (inHs) begin
                        tmo_q <= '0;
                        if (cnt_q == rxLen_q - 16'd1) begin
                            cnt_q   <= 16'd0;
                            state_q <= FIN;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end else if (!link_in_valid) begin
                        if (tmo_q == TMO_LAST) begin
                            error_q <= 1'b1;
                            abort_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                VER: begin
                    if (inHs) begin
                        version_q   <= link_in_data;
                        versionOk_q <= (link_in_data == EXPECTED_VERSION);
                        state_q     <= FIN;
                    end else if (tmo_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        abort_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                FIN: begin
                    done_q  <= (op_q != 2'd3);
                    error_q <= (op_q == 2'd3);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
